aes_encrypt_core: RTL

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

---
 rtl/aes_encrypt_core.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption, one round per clock.
//
// Ports
//   clk              in    1     sole clock, rising edge
//   rst_n            in    1     asynchronous active-low reset
//   start            in    1     request pulse, accepted only when idle
//   plain_text       in  128     plaintext, byte 0 at [127:120], column-major
//   round_keys_flat  in 1408     expanded key, round key r at [128*r +: 128]
//   cipher_text      out 128     registered ciphertext, held until next result
//   busy             out   1     high while an encryption is in flight
//   done             out   1     one-cycle pulse when cipher_text updates
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; inputs captured and key 0 applied on accept
// RUN   | applying rounds 1..10, one per clock; round 10 drops MixColumns
//
// Byte b of a 128-bit block sits at [127-8*b -: 8]; byte 4c+r is row r of
// column c.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; zero falls out as zero.
  logic [7:0] p2, p4, p8, p16, p32, p64, p128;
  logic [7:0] inv;

  always_comb begin
    p2   = gf_mul(in_byte, in_byte);
    p4   = gf_mul(p2, p2);
    p8   = gf_mul(p4, p4);
    p16  = gf_mul(p8, p8);
    p32  = gf_mul(p16, p16);
    p64  = gf_mul(p32, p32);
    p128 = gf_mul(p64, p64);
    inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                  gf_mul(gf_mul(p32, p64), p128));
  end

  // Affine step: b_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ 0x63_i,
  // i.e. x XOR its left rotations by 1..4.
  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

module aes_encrypt_core (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  plain_text,
  input  logic [1407:0] round_keys_flat,
  output logic [127:0]  cipher_text,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] cipher_q, cipher_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         key_load;

  logic [127:0] key_q [0:10];
  logic [127:0] round_key;
  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;

  genvar gi, gc, gr;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (state_q[127-8*gi -: 8]),
        .out_byte (sub_bytes[127-8*gi -: 8])
      );
    end

    // Row r rotates left by r: output column c takes input column (c+r)%4.
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign shift_rows[127-8*(4*gc+gr) -: 8] =
          sub_bytes[127-8*(4*((gc+gr)%4)+gr) -: 8];
      end
      assign mix_cols[127-32*gc -: 32] = mix_column(shift_rows[127-32*gc -: 32]);
    end
  endgenerate

  assign round_key = key_q[round_q];

  always_comb begin
    fsm_d    = fsm_q;
    round_d  = round_q;
    state_d  = state_q;
    cipher_d = cipher_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    key_load = 1'b0;
    case (fsm_q)
      RUN: begin
        if (round_q == 4'd10) begin
          cipher_d = shift_rows ^ round_key;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          round_d  = 4'd0;
          fsm_d    = IDLE;
        end else begin
          state_d = mix_cols ^ round_key;
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        if (start) begin
          key_load = 1'b1;
          state_d  = plain_text ^ round_keys_flat[127:0];
          round_d  = 4'd1;
          busy_d   = 1'b1;
          fsm_d    = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      round_q  <= 4'd0;
      state_q  <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      round_q  <= round_d;
      state_q  <= state_d;
      cipher_q <= cipher_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Captured key schedule is only read while RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    if (key_load) begin
      for (int r = 0; r < 11; r++) key_q[r] <= round_keys_flat[128*r +: 128];
    end
  end

  assign cipher_text = cipher_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
